// File: rtl/cpaf_pkg.sv
// Shared constants and field helpers for the CPA-free PE mesh output path.
package cpaf_pkg;
  localparam int unsigned SUM_W   = 35;
  localparam int unsigned CAR_W   = 36;
  localparam int unsigned C_W     = SUM_W + CAR_W;
  localparam int unsigned SHIFT_W = 5;
  localparam int unsigned OUT_W   = 32;
  localparam int unsigned CNT_W   = 16;

  localparam int unsigned V_W  = 37;        // exact width of sum+carry
  localparam int unsigned LO_W = 18;
  localparam int unsigned HI_W = V_W - LO_W;
  localparam int unsigned RW   = V_W + 1;   // headroom for the rounding increment

  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  function automatic logic [SUM_W-1:0] c_sum(input logic [C_W-1:0] c);
    return c[C_W-1:CAR_W];
  endfunction

  function automatic logic [CAR_W-1:0] c_car(input logic [C_W-1:0] c);
    return c[CAR_W-1:0];
  endfunction
endpackage

// File: rtl/cpaf_round_sat.sv
// Combinational round-half-up arithmetic right shift followed by signed saturation.
module cpaf_round_sat
  import cpaf_pkg::*;
(
  input  logic [V_W-1:0]     v,
  input  logic [SHIFT_W-1:0] shift,
  output logic [OUT_W-1:0]   data,
  output logic               sat
);
  logic signed [RW-1:0] ext;
  logic signed [RW-1:0] rnd;
  logic signed [RW-1:0] r;
  logic [RW-OUT_W:0]    top;

  always_comb begin
    ext = {v[V_W-1], v};
    rnd = '0;
    if (shift != '0)
      rnd = RW'(1) << (shift - 1'b1);
    r    = (ext + rnd) >>> shift;
    top  = r[RW-1:OUT_W-1];
    data = r[OUT_W-1:0];
    sat  = 1'b0;
    // Fits in OUT_W only if every bit above the result sign bit matches it.
    if (!(top == '0 || top == '1)) begin
      sat  = 1'b1;
      data = r[RW-1] ? SAT_MIN : SAT_MAX;
    end
  end
endmodule

// File: rtl/cpaf_result_resolver.sv
// Resolves a carry-save {sum,carry} word to binary via a split pipelined add, then rounds/saturates.
module cpaf_result_resolver
  import cpaf_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic [C_W-1:0]     io_in_c,
  input  logic [SHIFT_W-1:0] io_in_shift,
  input  logic               io_in_propagate,
  input  logic               io_in_valid,
  output logic               io_in_ready,
  output logic [OUT_W-1:0]   io_out_data,
  output logic               io_out_propagate,
  output logic               io_out_sat,
  output logic               io_out_valid,
  input  logic               io_out_ready,
  output logic [CNT_W-1:0]   io_out_count
);
  logic en;
  assign en          = ~(io_out_valid & ~io_out_ready);
  assign io_in_ready = en;

  logic [V_W-1:0]  a_ext, b_ext;
  logic [LO_W:0]   lo_add;
  logic [SUM_W-1:0] in_sum;
  logic [CAR_W-1:0] in_car;

  always_comb begin
    in_sum = c_sum(io_in_c);
    in_car = c_car(io_in_c);
    a_ext  = {{(V_W-SUM_W){in_sum[SUM_W-1]}}, in_sum};
    b_ext  = {{(V_W-CAR_W){in_car[CAR_W-1]}}, in_car};
    lo_add = {1'b0, a_ext[LO_W-1:0]} + {1'b0, b_ext[LO_W-1:0]};
  end

  logic               s1_valid, s1_cy, s1_prop;
  logic [LO_W-1:0]    s1_lo;
  logic [HI_W-1:0]    s1_a_hi, s1_b_hi;
  logic [SHIFT_W-1:0] s1_shift;

  logic               s2_valid, s2_prop;
  logic [V_W-1:0]     s2_v;
  logic [SHIFT_W-1:0] s2_shift;

  logic [HI_W-1:0]    hi_add;
  assign hi_add = s1_a_hi + s1_b_hi + {{(HI_W-1){1'b0}}, s1_cy};

  logic [OUT_W-1:0] rs_data;
  logic             rs_sat;

  cpaf_round_sat u_round_sat (
    .v     (s2_v),
    .shift (s2_shift),
    .data  (rs_data),
    .sat   (rs_sat)
  );

  // Single enable moves every stage together, so bubbles hold their slot during a stall.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_valid         <= 1'b0;
      s1_cy            <= 1'b0;
      s1_prop          <= 1'b0;
      s1_lo            <= '0;
      s1_a_hi          <= '0;
      s1_b_hi          <= '0;
      s1_shift         <= '0;
      s2_valid         <= 1'b0;
      s2_prop          <= 1'b0;
      s2_v             <= '0;
      s2_shift         <= '0;
      io_out_valid     <= 1'b0;
      io_out_data      <= '0;
      io_out_propagate <= 1'b0;
      io_out_sat       <= 1'b0;
    end else if (en) begin
      s1_valid <= io_in_valid;
      if (io_in_valid) begin
        s1_lo    <= lo_add[LO_W-1:0];
        s1_cy    <= lo_add[LO_W];
        s1_a_hi  <= a_ext[V_W-1:LO_W];
        s1_b_hi  <= b_ext[V_W-1:LO_W];
        s1_shift <= io_in_shift;
        s1_prop  <= io_in_propagate;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_v     <= {hi_add, s1_lo};
        s2_shift <= s1_shift;
        s2_prop  <= s1_prop;
      end
      io_out_valid <= s2_valid;
      if (s2_valid) begin
        io_out_data      <= rs_data;
        io_out_sat       <= rs_sat;
        io_out_propagate <= s2_prop;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      io_out_count <= '0;
    else if (io_out_valid && io_out_ready)
      io_out_count <= io_out_count + 1'b1;
  end
endmodule

// File: tb/tb_cpaf_result_resolver.sv
// Directed bench for cpaf_result_resolver: vector table plus stall and mid-stream reset sequences.
module tb_cpaf_result_resolver;
  import cpaf_pkg::*;

  logic               CLK = 1'b0;
  logic               RST;
  logic [C_W-1:0]     io_in_c;
  logic [SHIFT_W-1:0] io_in_shift;
  logic               io_in_propagate;
  logic               io_in_valid;
  logic               io_in_ready;
  logic [OUT_W-1:0]   io_out_data;
  logic               io_out_propagate;
  logic               io_out_sat;
  logic               io_out_valid;
  logic               io_out_ready;
  logic [CNT_W-1:0]   io_out_count;

  cpaf_result_resolver dut (
    .CLK              (CLK),
    .RST              (RST),
    .io_in_c          (io_in_c),
    .io_in_shift      (io_in_shift),
    .io_in_propagate  (io_in_propagate),
    .io_in_valid      (io_in_valid),
    .io_in_ready      (io_in_ready),
    .io_out_data      (io_out_data),
    .io_out_propagate (io_out_propagate),
    .io_out_sat       (io_out_sat),
    .io_out_valid     (io_out_valid),
    .io_out_ready     (io_out_ready),
    .io_out_count     (io_out_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [SUM_W-1:0]   sum;
    logic [CAR_W-1:0]   car;
    logic [SHIFT_W-1:0] sh;
    logic [OUT_W-1:0]   ed;
    logic               es;
  } vec_t;

  localparam int NV = 14;
  vec_t vt[NV];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mk(input longint s, input longint c, input int sh,
                              input longint ed, input bit es);
    vec_t v;
    v.sum = s[SUM_W-1:0];
    v.car = c[CAR_W-1:0];
    v.sh  = sh[SHIFT_W-1:0];
    v.ed  = ed[OUT_W-1:0];
    v.es  = es;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [SUM_W-1:0] s, input logic [CAR_W-1:0] c,
                       input logic [SHIFT_W-1:0] sh, input logic p);
    io_in_c         = {s, c};
    io_in_shift     = sh;
    io_in_propagate = p;
    io_in_valid     = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    #2;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    int idx, got, acc;
    logic hold_prev;
    logic [OUT_W-1:0] prev_data;
    logic prev_prop;
    bit seen;

    vt[0]  = mk(5, -3, 0, 2, 0);
    vt[1]  = mk(6, 0, 2, 2, 0);
    vt[2]  = mk(-6, 0, 2, -1, 0);
    vt[3]  = mk((64'sd1 <<< 34) - 1, 64'sd1 <<< 34, 0, 32'h7FFF_FFFF, 1);
    vt[4]  = mk(-(64'sd1 <<< 34), -(64'sd1 <<< 35), 0, 32'h8000_0000, 1);
    vt[5]  = mk(32'h3FFFF, 1, 0, 32'h40000, 0);
    vt[6]  = mk((64'sd1 <<< 34) - 1, 64'sd1 <<< 34, 31, 16, 0);
    vt[7]  = mk(-3, 0, 1, -1, 0);
    vt[8]  = mk(32'h7FFF_FFFF, 0, 0, 32'h7FFF_FFFF, 0);
    vt[9]  = mk(32'h7FFF_FFFF, 1, 0, 32'h7FFF_FFFF, 1);
    vt[10] = mk(-(64'sd1 <<< 31), 0, 0, 32'h8000_0000, 0);
    vt[11] = mk(-(64'sd1 <<< 31), -1, 0, 32'h8000_0000, 1);
    vt[12] = mk(7, 0, 1, 4, 0);
    vt[13] = mk(-32'sh40000, 32'h40001, 0, 1, 0);

    RST = 1'b0;
    io_in_c = '0; io_in_shift = '0; io_in_propagate = 1'b0;
    io_in_valid = 1'b0; io_out_ready = 1'b1;
    #12;
    chk("rst_valid", io_out_valid, 0);
    chk("rst_data",  io_out_data, 0);
    chk("rst_count", io_out_count, 0);
    chk("rst_ready", io_in_ready, 1);
    @(negedge CLK);
    RST = 1'b1;

    // Single words: valid must appear exactly three cycles after acceptance.
    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      drive(vt[i].sum, vt[i].car, vt[i].sh, i[0]);
      @(negedge CLK);
      io_in_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        #1;
        if (k < 3) begin
          chk($sformatf("lat_early%0d_v%0d", k, i), io_out_valid, 0);
          @(negedge CLK);
        end else begin
          chk($sformatf("lat_valid_v%0d", i), io_out_valid, 1);
          chk($sformatf("data_v%0d", i), io_out_data, vt[i].ed);
          chk($sformatf("sat_v%0d", i), io_out_sat, vt[i].es);
          chk($sformatf("prop_v%0d", i), io_out_propagate, i[0]);
        end
      end
    end
    @(negedge CLK);
    #1;
    chk("count_after_table", io_out_count, NV);

    // Stream of 8 with downstream stall in cycles 4..6.
    do_reset();
    idx = 0; got = 0; hold_prev = 1'b0; prev_data = '0; prev_prop = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      io_out_ready = !(cyc >= 4 && cyc <= 6);
      if (idx < 8) drive(35'(idx * 3 + 1), -36'(idx), 0, idx[0]);
      else io_in_valid = 1'b0;
      #1;
      chk($sformatf("in_ready_c%0d", cyc), io_in_ready, !(cyc >= 4 && cyc <= 6));
      if (hold_prev) begin
        chk("hold_data", io_out_data, prev_data);
        chk("hold_prop", io_out_propagate, prev_prop);
        chk("hold_valid", io_out_valid, 1);
      end
      if (io_out_valid && io_out_ready) begin
        chk($sformatf("stream_data%0d", got), io_out_data, 32'(2 * got + 1));
        chk($sformatf("stream_prop%0d", got), io_out_propagate, got[0]);
        got++;
      end
      hold_prev = io_out_valid && !io_out_ready;
      prev_data = io_out_data;
      prev_prop = io_out_propagate;
      acc = (io_in_valid && io_in_ready) ? 1 : 0;
      @(posedge CLK);
      idx += acc;
      @(negedge CLK);
    end
    io_in_valid = 1'b0;
    chk("stream_results", got, 8);
    #1;
    chk("stream_count", io_out_count, 8);

    // Mid-stream reset with the output stalled and words queued behind it.
    io_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(35'(100 + i), 0, 0, 1'b1);
      @(negedge CLK);
    end
    #1;
    chk("pre_rst_valid", io_out_valid, 1);
    chk("pre_rst_data", io_out_data, 100);
    #2;
    RST = 1'b0;
    #1;
    chk("midrst_valid", io_out_valid, 0);
    chk("midrst_data", io_out_data, 0);
    chk("midrst_prop", io_out_propagate, 0);
    chk("midrst_sat", io_out_sat, 0);
    chk("midrst_count", io_out_count, 0);
    chk("midrst_ready", io_in_ready, 1);
    io_in_valid = 1'b0;
    io_out_ready = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      #1;
      chk($sformatf("no_stale%0d", i), io_out_valid, 0);
    end
    drive(35'd9, 0, 0, 1'b0);
    @(negedge CLK);
    io_in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      #1;
      if (io_out_valid) begin
        seen = 1'b1;
        chk("post_rst_data", io_out_data, 9);
      end else @(negedge CLK);
    end
    chk("post_rst_seen", seen, 1);
    @(negedge CLK);
    #1;
    chk("post_rst_count", io_out_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
